// File: rtl/jkff_pkg.sv
// Shared definitions for the jkff built-in self test: state codes, JK input
// encodings, LFSR tap mask and the reference JK next-state function.
package jkff_pkg;

  // FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t RST   = 3'd1;
  localparam state_t RUN   = 3'd2;
  localparam state_t DRAIN = 3'd3;
  localparam state_t DONE  = 3'd4;

  // {j,k} encodings
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01
  function automatic logic [7:0] seed_fix(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

  // Reference JK flip-flop next state
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic [1:0] jk;
    jk = {j, k};
    case (jk)
      JK_HOLD:  return q;
      JK_RESET: return 1'b0;
      JK_SET:   return 1'b1;
      default:  return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_lfsr8.sv
// 8-bit Fibonacci LFSR (shift left, feedback into bit 0) that produces the
// pseudo-random j/k vectors. load has priority over en.
module jk_lfsr8
  import jkff_pkg::*;
#(
  parameter logic [7:0] INIT = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  output logic [7:0] value
);

  // Seed load on run start, advance once per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= INIT;
    end else if (load) begin
      value <= seed;
    end else if (en) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/jkff_bist.sv
// On-chip exerciser for a jkff instance: resets it, applies LFSR-driven j/k
// vectors, tracks a golden JK model and counts q/qnot mismatches.
module jkff_bist
  import jkff_pkg::*;
#(
  parameter int         NUM_VECTORS = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter int         ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q_in,
  input  logic             qnot_in,
  output logic             j,
  output logic             k,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0] SEED_EFF = seed_fix(LFSR_SEED);
  // Counter covers both the 2-cycle RST phase and the vector index
  localparam int VCW = $clog2(NUM_VECTORS + 2);
  localparam logic [VCW-1:0] VEC_LAST = VCW'(NUM_VECTORS - 1);
  localparam logic [VCW-1:0] RST_LAST = VCW'(1);

  state_t           state;
  logic [VCW-1:0]   vec_cnt;
  logic             exp_q;
  logic             chk_en;
  logic [7:0]       lfsr;
  logic             start_ok;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic             unused_lfsr_bits;

  // Only the two low LFSR bits form a vector
  assign unused_lfsr_bits = ^lfsr[7:2];

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  jk_lfsr8 #(
    .INIT (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_ok),
    .seed  (SEED_EFF),
    .en    (state == RUN),
    .value (lfsr)
  );

  // Mismatch detection and saturating error increment for this cycle
  always_comb begin
    mismatch = (q_in != exp_q) || (qnot_in == q_in);
    err_next = err_count;
    if (chk_en && mismatch && (err_count != {ERR_W{1'b1}})) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  // Golden model: follows the registered j/k/dut_reset the flop samples on this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= 1'b0;
    end else if ((state == RST) || dut_reset) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= jk_next(exp_q, j, k);
    end
  end

  // Sequencer: FSM, vector counter, registered stimulus, check window and result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      vec_cnt   <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      dut_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      chk_en    <= 1'b0;
    end else begin
      err_count <= err_next;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= RST;
            vec_cnt   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            dut_reset <= 1'b1;
            j         <= 1'b0;
            k         <= 1'b0;
          end
        end
        RST: begin
          j      <= 1'b0;
          k      <= 1'b0;
          chk_en <= 1'b0;
          if (vec_cnt == RST_LAST) begin
            state     <= RUN;
            vec_cnt   <= '0;
            dut_reset <= 1'b0;
          end else begin
            vec_cnt   <= vec_cnt + VCW'(1);
            dut_reset <= 1'b1;
          end
        end
        RUN: begin
          dut_reset <= 1'b0;
          {j, k}    <= lfsr[1:0];
          chk_en    <= 1'b1;
          if (vec_cnt == VEC_LAST) begin
            state <= DRAIN;
          end else begin
            vec_cnt <= vec_cnt + VCW'(1);
          end
        end
        DRAIN: begin
          // Last checked cycle: fold its result into pass
          state  <= DONE;
          j      <= 1'b0;
          k      <= 1'b0;
          chk_en <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          pass   <= (err_next == '0);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
